// File: rtl/alarma_ctrl_if.sv
// Operator / sensor bus of the alarm controller. The bench or host side
// drives the requests and sensor lines, the controller drives the status.
interface alarma_ctrl_if;
    logic       arm;
    logic       disarm;
    logic [2:0] sensor;
    logic       ack;
    logic [1:0] state;
    logic       armed;
    logic       pending;
    logic       siren;
    logic [7:0] event_count;

    modport master (
        output arm, disarm, sensor, ack,
        input  state, armed, pending, siren, event_count
    );

    modport slave (
        input  arm, disarm, sensor, ack,
        output state, armed, pending, siren, event_count
    );
endinterface

// File: rtl/alarma_ctrl.sv
// Intrusion alarm sequencer: debounced sensor trigger, entry delay, latched
// siren and a saturating count of raised alarms.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DISARMED  | idle, sensors ignored, waits for arm without disarm
// ARMED     | watching the debounced trigger
// PENDING   | entry delay running (ENTRY cycles), disarm aborts silently
// ALARM     | siren latched until ack (back to ARMED) or disarm
module alarma_ctrl #(
    parameter int DEB   = 3,
    parameter int ENTRY = 8
) (
    input logic         clk,
    input logic         rst,
    alarma_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_DISARMED = 2'd0,
        S_ARMED    = 2'd1,
        S_PENDING  = 2'd2,
        S_ALARM    = 2'd3
    } state_t;

    localparam logic [3:0] DEB_MAX  = 4'(DEB);
    localparam logic [3:0] DEB_TC   = 4'(DEB - 1);
    localparam logic [7:0] ENT_LOAD = 8'(ENTRY - 1);

    state_t     st_q, st_d;
    logic [3:0] deb_q, deb_d;
    logic [7:0] ent_q, ent_d;
    logic [7:0] evt_q, evt_d;
    logic       trig;
    logic       qual;

    // Raw trigger: A alone, or B and C together.
    assign trig = bus.sensor[2] | (bus.sensor[1] & bus.sensor[0]);
    // Qualifies on the DEB-th consecutive trigger edge (or later once saturated).
    assign qual = trig && (deb_q >= DEB_TC);

    // Next-state, entry down-counter, event counter and debounce update.
    always_comb begin
        st_d  = st_q;
        ent_d = ent_q;
        evt_d = evt_q;
        deb_d = deb_q;
        case (st_q)
            S_DISARMED: begin
                if (bus.arm && !bus.disarm) st_d = S_ARMED;
            end
            S_ARMED: begin
                if (bus.disarm) begin
                    st_d = S_DISARMED;
                end else if (qual) begin
                    st_d  = S_PENDING;
                    ent_d = ENT_LOAD;
                end
            end
            S_PENDING: begin
                if (bus.disarm) begin
                    st_d = S_DISARMED;
                end else if (ent_q == 8'd0) begin
                    st_d = S_ALARM;
                    if (evt_q != 8'hFF) evt_d = evt_q + 8'd1;
                end else begin
                    ent_d = ent_q - 8'd1;
                end
            end
            S_ALARM: begin
                if (bus.disarm) st_d = S_DISARMED;
                else if (bus.ack) st_d = S_ARMED;
            end
            default: st_d = S_DISARMED;
        endcase
        // Any state change restarts debounce so re-arming needs fresh samples.
        if (!trig || (st_d != st_q)) deb_d = 4'd0;
        else if (deb_q != DEB_MAX) deb_d = deb_q + 4'd1;
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= S_DISARMED;
            deb_q <= 4'd0;
            ent_q <= 8'd0;
            evt_q <= 8'd0;
        end else begin
            st_q  <= st_d;
            deb_q <= deb_d;
            ent_q <= ent_d;
            evt_q <= evt_d;
        end
    end

    assign bus.state       = st_q;
    assign bus.armed       = (st_q != S_DISARMED);
    assign bus.pending     = (st_q == S_PENDING);
    assign bus.siren       = (st_q == S_ALARM);
    assign bus.event_count = evt_q;

endmodule

// File: doc/alarma_ctrl.md
ALARMA_CTRL -- requirements
Module: alarma_ctrl

Interface
REQ-001 Parameter DEB, default 3, consecutive sampled cycles of trigger needed to qualify (range 1..15).
REQ-002 Parameter ENTRY, default 8, cycles spent in PENDING before alarm (range 1..255).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 arm  input  1  level request to arm the system.
REQ-006 disarm  input  1  level request to disarm; overrides every other input.
REQ-007 sensor  input  3  sensor lines {A,B,C} = sensor[2:0].
REQ-008 ack  input  1  operator acknowledge of a latched alarm.
REQ-009 state  output  2  current state: 0 DISARMED, 1 ARMED, 2 PENDING, 3 ALARM.
REQ-010 armed  output  1  high when state != DISARMED.
REQ-011 pending  output  1  high when state == PENDING.
REQ-012 siren  output  1  high when state == ALARM.
REQ-013 event_count  output  8  number of alarms raised since reset.

Function
REQ-014 Raw trigger t = A | (B & C), evaluated combinationally from sensor each cycle.
REQ-015 Debounce counter: increments on each edge with t=1, saturates at DEB; clears to 0 on any edge with t=0 and on any edge where state changes.
REQ-016 Qualified trigger q = 1 on an edge where t=1 and debounce counter == DEB-1 (or counter == DEB, saturated).
REQ-017 All outputs are registered or decoded solely from registered state; no combinational path from inputs to outputs.
REQ-018 DISARMED: arm=1 and disarm=0 -> ARMED; otherwise stay.
REQ-019 ARMED: disarm=1 -> DISARMED; else q=1 -> PENDING with entry counter loaded ENTRY-1; else stay.
REQ-020 PENDING: disarm=1 -> DISARMED, no event counted; else entry counter == 0 -> ALARM; else decrement entry counter.
REQ-021 PENDING lasts exactly ENTRY cycles when uninterrupted; sensor activity during PENDING is ignored.
REQ-022 ALARM: disarm=1 -> DISARMED; else ack=1 -> ARMED; else stay (siren latched; sensor ignored).
REQ-023 event_count increments by 1 on the PENDING->ALARM edge; saturates at 255, never wraps.
REQ-024 Simultaneous arm and disarm in any state: disarm wins.
REQ-025 Simultaneous ack and disarm in ALARM: DISARMED.
REQ-026 After ack to ARMED with t still high, re-alarm requires DEB fresh qualifying cycles (debounce cleared on transition).
REQ-027 arm, ack asserted in states where they have no defined effect are ignored.

Reset
REQ-028 rst=1 at an edge: state=DISARMED, armed=0, pending=0, siren=0, event_count=0, debounce and entry counters=0.
REQ-029 rst has priority over all inputs, including mid-PENDING and mid-ALARM; outputs at reset values on the cycle after the rst edge.
REQ-030 First state transition possible on the first edge with rst=0.

Verification (DEB=3, ENTRY=8)
REQ-031 Arm then sensor=3'b100 held: ARMED 1 cycle after arm; PENDING after 3rd t=1 edge; ALARM 8 cycles later; siren=1, event_count=1.
REQ-032 Glitch: sensor=3'b011 for 2 cycles then 3'b000 in ARMED -> remains ARMED, pending never asserts; sensor=3'b010 alone never triggers.
REQ-033 Disarm at PENDING cycle 5 -> DISARMED next edge, siren never asserts, event_count unchanged.
REQ-034 In ALARM: ack alone -> ARMED; with sensor still 3'b100, re-enter PENDING exactly 3 edges later; ack+disarm together -> DISARMED.
REQ-035 arm=disarm=1 in DISARMED -> stays DISARMED; 256 complete alarm cycles -> event_count stays 255.
REQ-036 rst=1 during ALARM with event_count=4 -> next cycle state=0, siren=0, event_count=0.
